// File: rtl/sched_controller.sv
// rtl/sched_controller.sv - Moore-FSM scheduler driving a paired ALU/MUL/LOGIC datapath
// Computes ((i1*i2)-i5)*((i3+i4)^i6) over four states; all outputs decode r_state only.
module sched_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] alu1_sel1,
    output logic [3:0] alu1_sel2,
    output logic       alu1_op,
    output logic [3:0] mul1_sel1,
    output logic [3:0] mul1_sel2,
    output logic       mul1_op,
    output logic [3:0] log1_sel1,
    output logic [3:0] log1_sel2,
    output logic [1:0] log1_op,
    output logic       reg_mul2_en,
    output logic       reg_alu4_en,
    output logic       reg_alu7_en,
    output logic       reg_log8_en,
    output logic       reg_mul10_en,
    output logic       result_en,
    output logic       done_next,
    output logic       busy
);

    localparam logic [3:0] SEL_I1     = 4'd0;
    localparam logic [3:0] SEL_I2     = 4'd1;
    localparam logic [3:0] SEL_I3     = 4'd2;
    localparam logic [3:0] SEL_I4     = 4'd3;
    localparam logic [3:0] SEL_I5     = 4'd4;
    localparam logic [3:0] SEL_I6     = 4'd5;
    localparam logic [3:0] SEL_MUL2   = 4'd6;
    localparam logic [3:0] SEL_ALU4   = 4'd7;
    localparam logic [3:0] SEL_ALU7   = 4'd8;
    localparam logic [3:0] SEL_LOG8   = 4'd9;

    localparam logic       ALU_ADD    = 1'b0;
    localparam logic       ALU_SUB    = 1'b1;
    localparam logic       MUL_MULT   = 1'b0;
    localparam logic [1:0] LOG_XOR    = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S1   = 3'd1,
        ST_S2   = 3'd2,
        ST_S3   = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // start only matters in IDLE; every other state advances unconditionally
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: w_next_state = start ? ST_S1 : ST_IDLE;
            ST_S1:   w_next_state = ST_S2;
            ST_S2:   w_next_state = ST_S3;
            ST_S3:   w_next_state = ST_FIN;
            ST_FIN:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        alu1_sel1    = 4'd0;
        alu1_sel2    = 4'd0;
        alu1_op      = ALU_ADD;
        mul1_sel1    = 4'd0;
        mul1_sel2    = 4'd0;
        mul1_op      = MUL_MULT;
        log1_sel1    = 4'd0;
        log1_sel2    = 4'd0;
        log1_op      = 2'b00;
        reg_mul2_en  = 1'b0;
        reg_alu4_en  = 1'b0;
        reg_alu7_en  = 1'b0;
        reg_log8_en  = 1'b0;
        reg_mul10_en = 1'b0;
        result_en    = 1'b0;
        done_next    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            ST_S1: begin
                mul1_sel1   = SEL_I1;
                mul1_sel2   = SEL_I2;
                mul1_op     = MUL_MULT;
                reg_mul2_en = 1'b1;
                alu1_sel1   = SEL_I3;
                alu1_sel2   = SEL_I4;
                alu1_op     = ALU_ADD;
                reg_alu4_en = 1'b1;
                busy        = 1'b1;
            end
            ST_S2: begin
                alu1_sel1   = SEL_MUL2;
                alu1_sel2   = SEL_I5;
                alu1_op     = ALU_SUB;
                reg_alu7_en = 1'b1;
                log1_sel1   = SEL_ALU4;
                log1_sel2   = SEL_I6;
                log1_op     = LOG_XOR;
                reg_log8_en = 1'b1;
                busy        = 1'b1;
            end
            ST_S3: begin
                mul1_sel1    = SEL_ALU7;
                mul1_sel2    = SEL_LOG8;
                mul1_op      = MUL_MULT;
                reg_mul10_en = 1'b1;
                busy         = 1'b1;
            end
            ST_FIN: begin
                result_en = 1'b1;
                done_next = 1'b1;
                busy      = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_sched_controller.sv
// tb/tb_sched_controller.sv - bench for sched_controller with a reference datapath and result scoreboard
module tb_sched_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] alu1_sel1, alu1_sel2, mul1_sel1, mul1_sel2, log1_sel1, log1_sel2;
    logic       alu1_op, mul1_op;
    logic [1:0] log1_op;
    logic       reg_mul2_en, reg_alu4_en, reg_alu7_en, reg_log8_en, reg_mul10_en;
    logic       result_en, done_next, busy;

    sched_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .alu1_sel1(alu1_sel1), .alu1_sel2(alu1_sel2), .alu1_op(alu1_op),
        .mul1_sel1(mul1_sel1), .mul1_sel2(mul1_sel2), .mul1_op(mul1_op),
        .log1_sel1(log1_sel1), .log1_sel2(log1_sel2), .log1_op(log1_op),
        .reg_mul2_en(reg_mul2_en), .reg_alu4_en(reg_alu4_en), .reg_alu7_en(reg_alu7_en),
        .reg_log8_en(reg_log8_en), .reg_mul10_en(reg_mul10_en),
        .result_en(result_en), .done_next(done_next), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [35:0] obs_vec;
    assign obs_vec = {alu1_sel1, alu1_sel2, alu1_op, mul1_sel1, mul1_sel2, mul1_op,
                      log1_sel1, log1_sel2, log1_op,
                      reg_mul2_en, reg_alu4_en, reg_alu7_en, reg_log8_en, reg_mul10_en,
                      result_en, done_next, busy};

    localparam logic [35:0] V_IDLE = 36'd0;
    localparam logic [35:0] V_S1   = {4'd2, 4'd3, 1'b0, 4'd0, 4'd1, 1'b0, 4'd0, 4'd0, 2'd0, 5'b11000, 3'b001};
    localparam logic [35:0] V_S2   = {4'd6, 4'd4, 1'b1, 4'd0, 4'd0, 1'b0, 4'd7, 4'd5, 2'd2, 5'b00110, 3'b001};
    localparam logic [35:0] V_S3   = {4'd0, 4'd0, 1'b0, 4'd8, 4'd9, 1'b0, 4'd0, 4'd0, 2'd0, 5'b00001, 3'b001};
    localparam logic [35:0] V_FIN  = {4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 2'd0, 5'b00000, 3'b111};

    // Reference datapath steered only by the controller outputs
    logic [31:0] i1, i2, i3, i4, i5, i6;
    logic [31:0] dp_mul2, dp_alu4, dp_alu7, dp_log8, dp_mul10, dp_result;
    logic        dp_done;
    logic [31:0] a_op1, a_op2, m_op1, m_op2, l_op1, l_op2, alu_out, mul_out, log_out;

    function automatic logic [31:0] pick(input logic [3:0] s,
                                         input logic [31:0] v1, v2, v3, v4, v5, v6,
                                         input logic [31:0] r6, r7, r8, r9, r10);
        case (s)
            4'd0: pick = v1;
            4'd1: pick = v2;
            4'd2: pick = v3;
            4'd3: pick = v4;
            4'd4: pick = v5;
            4'd5: pick = v6;
            4'd6: pick = r6;
            4'd7: pick = r7;
            4'd8: pick = r8;
            4'd9: pick = r9;
            4'd10: pick = r10;
            default: pick = 32'd0;
        endcase
    endfunction

    always_comb begin
        a_op1 = pick(alu1_sel1, i1, i2, i3, i4, i5, i6, dp_mul2, dp_alu4, dp_alu7, dp_log8, dp_mul10);
        a_op2 = pick(alu1_sel2, i1, i2, i3, i4, i5, i6, dp_mul2, dp_alu4, dp_alu7, dp_log8, dp_mul10);
        m_op1 = pick(mul1_sel1, i1, i2, i3, i4, i5, i6, dp_mul2, dp_alu4, dp_alu7, dp_log8, dp_mul10);
        m_op2 = pick(mul1_sel2, i1, i2, i3, i4, i5, i6, dp_mul2, dp_alu4, dp_alu7, dp_log8, dp_mul10);
        l_op1 = pick(log1_sel1, i1, i2, i3, i4, i5, i6, dp_mul2, dp_alu4, dp_alu7, dp_log8, dp_mul10);
        l_op2 = pick(log1_sel2, i1, i2, i3, i4, i5, i6, dp_mul2, dp_alu4, dp_alu7, dp_log8, dp_mul10);
        alu_out = alu1_op ? (a_op1 - a_op2) : (a_op1 + a_op2);
        mul_out = mul1_op ? ((m_op2 == 32'd0) ? 32'd0 : (m_op1 / m_op2)) : (m_op1 * m_op2);
        case (log1_op)
            2'b00:   log_out = l_op1 & l_op2;
            2'b01:   log_out = l_op1 | l_op2;
            2'b10:   log_out = l_op1 ^ l_op2;
            default: log_out = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_mul2 <= '0; dp_alu4 <= '0; dp_alu7 <= '0; dp_log8 <= '0;
            dp_mul10 <= '0; dp_result <= '0; dp_done <= 1'b0;
        end else begin
            if (reg_mul2_en)  dp_mul2  <= mul_out;
            if (reg_alu4_en)  dp_alu4  <= alu_out;
            if (reg_alu7_en)  dp_alu7  <= alu_out;
            if (reg_log8_en)  dp_log8  <= log_out;
            if (reg_mul10_en) dp_mul10 <= mul_out;
            if (result_en)    dp_result <= dp_mul10;
            dp_done <= done_next;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] q_exp_res[$];
    int          q_exp_cyc[$];
    logic [31:0] q_obs_res[$];
    int          q_obs_cyc[$];

    always @(negedge clk) begin
        if (dp_done) begin
            q_obs_res.push_back(dp_result);
            q_obs_cyc.push_back(cyc);
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] model(input logic [31:0] a1, a2, a3, a4, a5, a6);
        model = ((a1 * a2) - a5) * ((a3 + a4) ^ a6);
    endfunction

    task automatic set_inputs(input logic [31:0] a1, a2, a3, a4, a5, a6);
        i1 = a1; i2 = a2; i3 = a3; i4 = a4; i5 = a5; i6 = a6;
    endtask

    task automatic clear_sb();
        q_exp_res.delete(); q_exp_cyc.delete();
        q_obs_res.delete(); q_obs_cyc.delete();
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_sb();
        set_inputs(32'd7, 32'd2, 32'd1, 32'd1, 32'd4, 32'd3);
        rst_n = 1'b0;
        start = 1'b1;
        #1;
        n_tests++;
        if (obs_vec !== V_IDLE) begin n_fail++; $display("FAIL reset_outputs got %h want %h", obs_vec, V_IDLE); end
        step(); step();
        n_tests++;
        if (obs_vec !== V_IDLE || dp_done !== 1'b0) begin n_fail++; $display("FAIL reset_hold got %h want %h", obs_vec, V_IDLE); end
        rst_n = 1'b1;
        q_exp_res.push_back(model(i1, i2, i3, i4, i5, i6));
        q_exp_cyc.push_back(cyc + 5);
        step();
        start = 1'b0;
        n_tests++;
        if (obs_vec !== V_S1) begin n_fail++; $display("FAIL first_edge_idle got %h want %h", obs_vec, V_S1); end
        for (int k = 0; k < 10 && q_obs_res.size() == 0; k++) step();
        n_tests++;
        if (q_obs_res.size() != 1) begin
            n_fail++; $display("FAIL reset_release_run got %0d dones want 1", q_obs_res.size());
        end else if (q_obs_res[0] !== q_exp_res[0] || q_obs_cyc[0] != q_exp_cyc[0]) begin
            n_fail++; $display("FAIL reset_release_run got %h@%0d want %h@%0d", q_obs_res[0], q_obs_cyc[0], q_exp_res[0], q_exp_cyc[0]);
        end
        step(); step();
    endtask

    task automatic test_state_outputs();
        logic [35:0] exp_v [5];
        clear_sb();
        exp_v[0] = V_S1; exp_v[1] = V_S2; exp_v[2] = V_S3; exp_v[3] = V_FIN; exp_v[4] = V_IDLE;
        set_inputs(32'd9, 32'd5, 32'd12, 32'd30, 32'd7, 32'd255);
        step();
        n_tests++;
        if (obs_vec !== V_IDLE) begin n_fail++; $display("FAIL state_IDLE got %h want %h", obs_vec, V_IDLE); end
        start = 1'b1;
        for (int s = 0; s < 5; s++) begin
            step();
            start = 1'b0;
            n_tests++;
            if (obs_vec !== exp_v[s]) begin n_fail++; $display("FAIL state_vec_%0d got %h want %h", s, obs_vec, exp_v[s]); end
        end
        n_tests++;
        if (dp_result !== model(i1, i2, i3, i4, i5, i6)) begin
            n_fail++; $display("FAIL state_run_result got %h want %h", dp_result, model(i1, i2, i3, i4, i5, i6));
        end
    endtask

    task automatic test_basic();
        int n;
        clear_sb();
        set_inputs(32'd3, 32'd4, 32'd5, 32'd6, 32'd2, 32'd1);
        step();
        n = cyc + 1;
        q_exp_res.push_back(32'd100);
        q_exp_cyc.push_back(n + 4);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 10 && q_obs_res.size() == 0; k++) step();
        n_tests++;
        if (q_obs_res.size() != 1) begin
            n_fail++; $display("FAIL basic_done got %0d dones want 1", q_obs_res.size());
        end else if (q_obs_res[0] !== q_exp_res[0] || q_obs_cyc[0] != q_exp_cyc[0]) begin
            n_fail++; $display("FAIL basic_result got %0d@%0d want %0d@%0d", q_obs_res[0], q_obs_cyc[0], q_exp_res[0], q_exp_cyc[0]);
        end
        n_tests++;
        if ({dp_mul2, dp_alu4, dp_alu7, dp_log8} !== {32'd12, 32'd11, 32'd10, 32'd10}) begin
            n_fail++; $display("FAIL basic_intermediates got %0d %0d %0d %0d want 12 11 10 10", dp_mul2, dp_alu4, dp_alu7, dp_log8);
        end
        step();
        n_tests++;
        if (dp_done !== 1'b0 || q_obs_res.size() != 1) begin
            n_fail++; $display("FAIL basic_done_width got %b want 0", dp_done);
        end
    endtask

    task automatic test_wrap();
        clear_sb();
        set_inputs(32'h10000, 32'h10000, 32'd0, 32'd1, 32'd1, 32'd0);
        step();
        q_exp_res.push_back(32'hFFFF_FFFF);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 10 && q_obs_res.size() == 0; k++) step();
        n_tests++;
        if (q_obs_res.size() != 1) begin
            n_fail++; $display("FAIL wrap_done got %0d dones want 1", q_obs_res.size());
        end else if (q_obs_res[0] !== q_exp_res[0] || dp_alu7 !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL wrap_result got %h alu7 %h want %h alu7 ffffffff", q_obs_res[0], dp_alu7, q_exp_res[0]);
        end
    endtask

    task automatic test_start_in_s2();
        int n;
        clear_sb();
        set_inputs($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        step();
        n = cyc + 1;
        q_exp_res.push_back(model(i1, i2, i3, i4, i5, i6));
        q_exp_cyc.push_back(n + 4);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (q_obs_res.size() == 1 && q_obs_cyc[0] == cyc) begin
                n_tests++;
                if (busy !== 1'b0) begin n_fail++; $display("FAIL s2_busy_after_fin got %b want 0", busy); end
            end
        end
        n_tests++;
        if (q_obs_res.size() != 1) begin
            n_fail++; $display("FAIL s2_restart got %0d dones want 1", q_obs_res.size());
        end else if (q_obs_res[0] !== q_exp_res[0] || q_obs_cyc[0] != q_exp_cyc[0]) begin
            n_fail++; $display("FAIL s2_result got %h@%0d want %h@%0d", q_obs_res[0], q_obs_cyc[0], q_exp_res[0], q_exp_cyc[0]);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        clear_sb();
        set_inputs($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        step();
        n = cyc + 1;
        for (int r = 0; r < 3; r++) begin
            q_exp_res.push_back(model(i1, i2, i3, i4, i5, i6));
            q_exp_cyc.push_back(n + 4 + 5 * r);
        end
        start = 1'b1;
        for (int k = 0; k < 12; k++) step();
        start = 1'b0;
        for (int k = 0; k < 20 && q_obs_res.size() < 3; k++) step();
        step(); step();
        n_tests++;
        if (q_obs_res.size() != 3) begin
            n_fail++; $display("FAIL b2b_count got %0d dones want 3", q_obs_res.size());
        end
        while (q_obs_res.size() > 0 && q_exp_res.size() > 0) begin
            logic [31:0] orr, err;
            int oc, ec;
            orr = q_obs_res.pop_front(); oc = q_obs_cyc.pop_front();
            err = q_exp_res.pop_front(); ec = q_exp_cyc.pop_front();
            n_tests++;
            if (orr !== err || oc != ec) begin
                n_fail++; $display("FAIL b2b_run got %h@%0d want %h@%0d", orr, oc, err, ec);
            end
        end
    endtask

    task automatic test_reset_midrun();
        clear_sb();
        set_inputs(32'd3, 32'd4, 32'd5, 32'd6, 32'd2, 32'd1);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        @(posedge clk);
        #2;
        n_tests++;
        if (obs_vec !== V_S2) begin n_fail++; $display("FAIL midrun_in_s2 got %h want %h", obs_vec, V_S2); end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs_vec !== V_IDLE) begin n_fail++; $display("FAIL async_reset got %h want %h", obs_vec, V_IDLE); end
        step(); step();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) step();
        n_tests++;
        if (q_obs_res.size() != 0 || obs_vec !== V_IDLE) begin
            n_fail++; $display("FAIL abandoned_run got %0d dones state %h want 0 dones idle", q_obs_res.size(), obs_vec);
        end
        set_inputs(32'd6, 32'd7, 32'd1, 32'd2, 32'd5, 32'd8);
        q_exp_res.push_back(model(i1, i2, i3, i4, i5, i6));
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 10 && q_obs_res.size() == 0; k++) step();
        n_tests++;
        if (q_obs_res.size() != 1) begin
            n_fail++; $display("FAIL post_reset_run got %0d dones want 1", q_obs_res.size());
        end else if (q_obs_res[0] !== q_exp_res[0]) begin
            n_fail++; $display("FAIL post_reset_result got %h want %h", q_obs_res[0], q_exp_res[0]);
        end
    endtask

    initial begin
        set_inputs(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        test_reset();
        test_state_outputs();
        test_basic();
        test_wrap();
        test_start_in_s2();
        test_back_to_back();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sched_controller.md
SCHED_CONTROLLER -- requirements
Module: sched_controller

Interface
REQ-001 Ports SHALL be, in order:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request one evaluation; sampled only in IDLE.
- alu1_sel1, alu1_sel2  output  4 each  ALU operand selects.
- alu1_op  output  1  0=ADD, 1=SUB.
- mul1_sel1, mul1_sel2  output  4 each  multiplier operand selects.
- mul1_op  output  1  0=MULT, 1=DIV.
- log1_sel1, log1_sel2  output  4 each  logic-unit operand selects.
- log1_op  output  2  00=AND, 01=OR, 10=XOR.
- reg_mul2_en, reg_alu4_en, reg_alu7_en, reg_log8_en, reg_mul10_en  output  1 each  intermediate register load enables.
- result_en  output  1  load result from reg_mul10.
- done_next  output  1  datapath registers this as done.
- busy  output  1  high in any state except IDLE.
REQ-002 Operand select encoding SHALL be 0..5 = i1..i6, 6 = reg_mul2, 7 = reg_alu4, 8 = reg_alu7, 9 = reg_log8, 10 = reg_mul10.
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 The block SHALL be a Moore FSM with states IDLE, S1, S2, S3 and FIN; all outputs SHALL be decoded from the state register only.
REQ-005 State transitions SHALL be:
- IDLE goes to S1 when start=1, else stays in IDLE.
- S1 goes to S2, S2 goes to S3, and S3 goes to FIN, each unconditionally.
- FIN goes to IDLE unconditionally.
REQ-006 In S1 the outputs SHALL be:
- mul1_sel1=0, mul1_sel2=1, mul1_op=0, reg_mul2_en=1 (i1*i2).
- alu1_sel1=2, alu1_sel2=3, alu1_op=0, reg_alu4_en=1 (i3+i4).
REQ-007 In S2 the outputs SHALL be:
- alu1_sel1=6, alu1_sel2=4, alu1_op=1, reg_alu7_en=1 (reg_mul2-i5).
- log1_sel1=7, log1_sel2=5, log1_op=2'b10, reg_log8_en=1 (reg_alu4^i6).
REQ-008 In S3 the outputs SHALL be mul1_sel1=8, mul1_sel2=9, mul1_op=0, reg_mul10_en=1 (reg_alu7*reg_log8).
REQ-009 In FIN the outputs SHALL be result_en=1 and done_next=1.
REQ-010 Any select, op or enable not named for the current state SHALL be 0, including all of them in IDLE.
REQ-011 busy SHALL be high in S1, S2, S3 and FIN.
REQ-012 Latency: with start sampled in IDLE at edge N, the datapath result and done SHALL be valid after edge N+4, and done SHALL be high for exactly one cycle.
REQ-013 With the paired datapath, result SHALL equal ((i1*i2)-i5)*((i3+i4)^i6), truncated mod 2^32 with unsigned wrap-around.
REQ-014 start SHALL be ignored in S1..FIN; a run is never extended or restarted by start.
REQ-015 start held high continuously SHALL produce back-to-back runs with a 5-cycle period (IDLE, S1, S2, S3, FIN).
REQ-016 No enable SHALL be asserted in two consecutive states for the same register, and no two FIN cycles SHALL be adjacent.

Reset
REQ-017 rst_n=0 SHALL force the state to IDLE immediately, without waiting for a clock edge, and hold it there while low.
REQ-018 During reset all outputs SHALL be 0, including busy and done_next.
REQ-019 Reset asserted mid-run SHALL abandon the run: no result_en and no done_next until a new start is accepted after release.
REQ-020 The first edge after rst_n rises SHALL be treated as an IDLE cycle.

Verification
REQ-021 Basic run: i1=3, i2=4, i3=5, i4=6, i5=2, i6=1, one-cycle start pulse -> reg_mul2=12, reg_alu4=11, reg_alu7=10, reg_log8=10, result=100, done high for 1 cycle, 4 edges after start is sampled.
REQ-022 Wrap-around: i1=32'h10000, i2=32'h10000, i5=1, i3=0, i4=1, i6=0 -> reg_alu7=32'hFFFFFFFF, result=32'hFFFFFFFF.
REQ-023 start pulsed again in S2 -> ignored; exactly one done; busy falls after FIN.
REQ-024 start held high for 12 cycles -> done pulses 5 cycles apart, each run producing the correct result.
REQ-025 rst_n pulled low asynchronously (between clock edges) in S2 -> busy=0 and all enables=0 without a clock edge; no done afterwards; a fresh start then yields the correct result.
REQ-026 Per-state output check: every output in each of IDLE, S1, S2, S3 and FIN compared against REQ-006..REQ-010, with any non-listed output nonzero flagged as an error.
